// File: rtl/mem_bist.sv
// March-style memory BIST initiator: write P(a), read/check P(a), write ~P(a), read/check ~P(a).
// Reports pass/fail, the first failing address/data and a saturating miscompare count.
module mem_bist #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [7:0]            err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  read,
  output logic                  write
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR0  = 3'd1,
    RD0  = 3'd2,
    WR1  = 3'd3,
    RD1  = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [ADDR_WIDTH:0] IDX_ZERO    = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0] IDX_ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] IDX_LAST_WR = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [ADDR_WIDTH:0] IDX_LAST_RD = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [7:0]          ERR_MAX     = 8'd255;

  // Address zero-extended or truncated to the data width, optionally inverted.
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a,
                                                    input logic inv);
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] ext;
    ext = {{DATA_WIDTH{1'b0}}, a};
    pattern = inv ? ~ext[DATA_WIDTH-1:0] : ext[DATA_WIDTH-1:0];
  endfunction

  state_t                  state_r, state_s;
  logic [ADDR_WIDTH:0]     idx_r, idx_s;
  logic                    pipe_valid_r;
  logic [ADDR_WIDTH-1:0]   pipe_addr_r;
  logic                    pipe_inv_r;

  logic                    start_ok_s;
  logic                    miscmp_s;
  logic                    busy_s, done_s, pass_s, read_s, write_s;
  logic [ADDR_WIDTH-1:0]   addr_s;
  logic [DATA_WIDTH-1:0]   data_out_s;
  logic [7:0]              err_s;
  logic [ADDR_WIDTH-1:0]   fail_addr_s;
  logic [DATA_WIDTH-1:0]   fail_data_s;

  // Next state and per-phase cycle index.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s = WR0;
          idx_s   = IDX_ZERO;
        end else begin
          state_s = state_r;
          idx_s   = idx_r;
        end
      end
      WR0, WR1: begin
        if (idx_r == IDX_LAST_WR) begin
          if (state_r == WR0) begin
            state_s = RD0;
          end else begin
            state_s = RD1;
          end
          idx_s = IDX_ZERO;
        end else begin
          state_s = state_r;
          idx_s   = idx_r + IDX_ONE;
        end
      end
      RD0, RD1: begin
        if (idx_r == IDX_LAST_RD) begin
          if (state_r == RD0) begin
            state_s = WR1;
          end else begin
            state_s = DONE;
          end
          idx_s = IDX_ZERO;
        end else begin
          state_s = state_r;
          idx_s   = idx_r + IDX_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = IDX_ZERO;
      end
    endcase
  end

  // Bus-side outputs decoded from the next state so they register alongside it.
  always_comb begin
    busy_s     = 1'b0;
    done_s     = 1'b0;
    write_s    = 1'b0;
    read_s     = 1'b0;
    addr_s     = {ADDR_WIDTH{1'b0}};
    data_out_s = {DATA_WIDTH{1'b0}};
    case (state_s)
      WR0, WR1: begin
        busy_s     = 1'b1;
        write_s    = 1'b1;
        addr_s     = idx_s[ADDR_WIDTH-1:0];
        data_out_s = pattern(idx_s[ADDR_WIDTH-1:0], (state_s == WR1));
      end
      RD0, RD1: begin
        busy_s = 1'b1;
        // Index N is the trailing compare-only cycle.
        read_s = ~idx_s[ADDR_WIDTH];
        if (read_s) begin
          addr_s = idx_s[ADDR_WIDTH-1:0];
        end else begin
          addr_s = {ADDR_WIDTH{1'b0}};
        end
      end
      DONE: begin
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Compare the returned word against the pattern of the address read last cycle.
  always_comb begin
    start_ok_s  = start && ((state_r == IDLE) || (state_r == DONE));
    miscmp_s    = pipe_valid_r && (data_in != pattern(pipe_addr_r, pipe_inv_r));
    err_s       = err_count;
    fail_addr_s = fail_addr;
    fail_data_s = fail_data;
    if (start_ok_s) begin
      err_s       = 8'd0;
      fail_addr_s = {ADDR_WIDTH{1'b0}};
      fail_data_s = {DATA_WIDTH{1'b0}};
    end else if (miscmp_s) begin
      if (err_count != ERR_MAX) begin
        err_s = err_count + 8'd1;
      end else begin
        err_s = err_count;
      end
      if (err_count == 8'd0) begin
        fail_addr_s = pipe_addr_r;
        fail_data_s = data_in;
      end else begin
        fail_addr_s = fail_addr;
        fail_data_s = fail_data;
      end
    end else begin
      err_s = err_count;
    end
    pass_s = done_s && (err_s == 8'd0);
  end

  // State, compare pipeline and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      idx_r        <= IDX_ZERO;
      pipe_valid_r <= 1'b0;
      pipe_addr_r  <= {ADDR_WIDTH{1'b0}};
      pipe_inv_r   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      read         <= 1'b0;
      write        <= 1'b0;
      addr         <= {ADDR_WIDTH{1'b0}};
      data_out     <= {DATA_WIDTH{1'b0}};
      err_count    <= 8'd0;
      fail_addr    <= {ADDR_WIDTH{1'b0}};
      fail_data    <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      pipe_valid_r <= read;
      pipe_addr_r  <= addr;
      pipe_inv_r   <= (state_r == RD1);
      busy         <= busy_s;
      done         <= done_s;
      pass         <= pass_s;
      read         <= read_s;
      write        <= write_s;
      addr         <= addr_s;
      data_out     <= data_out_s;
      err_count    <= err_s;
      fail_addr    <= fail_addr_s;
      fail_data    <= fail_data_s;
    end
  end

endmodule

// File: tb/tb_mem_bist.sv
// Randomized bench for mem_bist: a 32x8 and a 256x8 instance, each on a behavioural memory
// with injectable stuck-at masks, checked against a march-level reference model.
module tb_mem_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, sel_big;
  logic [7:0] s0_mask, s1_mask, const_val;
  logic       const_en;
  int         total, bad;

  logic       start_a, busy_a, done_a, pass_a, read_a, write_a;
  logic [7:0] err_a, fd_a, dout_a, din_a, rd_a;
  logic [4:0] fa_a, addr_a;
  logic       start_b, busy_b, done_b, pass_b, read_b, write_b;
  logic [7:0] err_b, fd_b, dout_b, din_b, rd_b, fa_b, addr_b;

  assign start_a = start & ~sel_big;
  assign start_b = start & sel_big;

  mem_bist #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .fail_addr(fa_a), .fail_data(fd_a), .addr(addr_a), .data_out(dout_a),
    .data_in(din_a), .read(read_a), .write(write_a));

  mem_bist #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .fail_addr(fa_b), .fail_data(fd_b), .addr(addr_b), .data_out(dout_b),
    .data_in(din_b), .read(read_b), .write(write_b));

  logic [7:0] mem_a [32];
  logic [7:0] mem_b [256];

  // Synchronous memories: write on the edge ending the cycle, read data valid the next cycle.
  always @(posedge clk) begin
    if (write_a) mem_a[addr_a] <= dout_a;
    if (read_a)  rd_a <= mem_a[addr_a];
    if (write_b) mem_b[addr_b] <= dout_b;
    if (read_b)  rd_b <= mem_b[addr_b];
  end

  assign din_a = const_en ? const_val : ((rd_a & ~s0_mask) | s1_mask);
  assign din_b = const_en ? const_val : ((rd_b & ~s0_mask) | s1_mask);

  logic       busy_m, done_m, pass_m, read_m, write_m;
  logic [7:0] err_m, fa_m, fd_m, addr_m, dout_m;
  assign busy_m  = sel_big ? busy_b  : busy_a;
  assign done_m  = sel_big ? done_b  : done_a;
  assign pass_m  = sel_big ? pass_b  : pass_a;
  assign read_m  = sel_big ? read_b  : read_a;
  assign write_m = sel_big ? write_b : write_a;
  assign err_m   = sel_big ? err_b   : err_a;
  assign fa_m    = sel_big ? fa_b    : {3'b000, fa_a};
  assign fd_m    = sel_big ? fd_b    : fd_a;
  assign addr_m  = sel_big ? addr_b  : {3'b000, addr_a};
  assign dout_m  = sel_big ? dout_b  : dout_a;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // March reference: two write/read passes; every read of address a sees the stored word
  // distorted by the stuck masks (or a constant), compared to the word that pass wrote.
  task automatic predict(input int n, input logic [7:0] s0, input logic [7:0] s1,
                         input bit ce, input logic [7:0] cv,
                         output int e, output int fa, output int fd);
    logic [7:0] want, got;
    e = 0; fa = 0; fd = 0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int a = 0; a < n; a++) begin
        want = (ph == 0) ? 8'(a) : ~8'(a);
        got  = ce ? cv : ((want & ~s0) | s1);
        if (got != want) begin
          if (e == 0) begin fa = a; fd = int'(got); end
          if (e < 255) e++;
        end
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ctrl"}, {busy_a, done_a, pass_a, read_a, write_a}, 0);
    check({tag, "_regs"}, {err_a, fa_a, fd_a, addr_a}, 0);
    check({tag, "_dout"}, dout_a, 0);
  endtask

  task automatic run_bist(input bit big, input logic [7:0] s0, input logic [7:0] s1,
                          input bit ce, input logic [7:0] cv, input int ign_at);
    int n, cyc, nbusy, nwr, nrd, seq_bad, e, fa, fd, ea;
    logic [7:0] ed;
    n = big ? 256 : 32;
    sel_big = big; s0_mask = s0; s1_mask = s1; const_en = ce; const_val = cv;
    predict(n, s0, s1, ce, cv, e, fa, fd);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("first_busy", busy_m, 1);
    check("first_write", write_m, 1);
    check("first_addr", addr_m, 0);
    check("first_data", dout_m, 0);
    check("start_clears_done", done_m, 0);
    check("start_clears_err", err_m, 0);
    cyc = 0; nbusy = 0; nwr = 0; nrd = 0; seq_bad = 0;
    while (!done_m && cyc < 4 * n + 20) begin
      if (busy_m) nbusy++;
      if (read_m && write_m) seq_bad++;
      if (write_m) begin
        ea = nwr % n;
        ed = (nwr < n) ? 8'(ea) : ~8'(ea);
        if (addr_m != 8'(ea) || dout_m != ed) seq_bad++;
        nwr++;
      end
      if (read_m) begin
        if (addr_m != 8'(nrd % n)) seq_bad++;
        nrd++;
      end
      start = (cyc == ign_at);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done_reached", done_m, 1);
    check("busy_cycles", nbusy, 4 * n + 2);
    check("write_cycles", nwr, 2 * n);
    check("read_cycles", nrd, 2 * n);
    check("bus_sequence", seq_bad, 0);
    check("err_count", err_m, e);
    check("fail_addr", fa_m, fa);
    check("fail_data", fd_m, fd);
    check("pass", pass_m, (e == 0) ? 1 : 0);
    check("done_bus_idle", {busy_m, read_m, write_m, addr_m}, 0);
  endtask

  task automatic reset_mid(input int k);
    sel_big = 1'b0; s0_mask = 8'h00; s1_mask = 8'h00; const_en = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (k) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle("midrst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_hold", {busy_a, read_a, write_a}, 0);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; start = 1'b0; sel_big = 1'b0;
    s0_mask = 8'h00; s1_mask = 8'h00; const_en = 1'b0; const_val = 8'h00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = ~start;
      check_idle("reset");
    end
    start = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); check_idle("idle");

    run_bist(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 50);
    run_bist(1'b0, 8'h01, 8'h00, 1'b0, 8'h00, -1);
    check("sa0_err", err_a, 32);
    check("sa0_fail_addr", fa_a, 1);
    check("sa0_fail_data", fd_a, 0);
    run_bist(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, -1);
    check("restart_pass", pass_a, 1);

    reset_mid(40);
    run_bist(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, -1);
    reset_mid($urandom_range(1, 120));
    run_bist(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, $urandom_range(1, 128));

    for (int r = 0; r < 6; r++) begin
      logic [7:0] m0, m1;
      m0 = 8'($urandom & $urandom);
      m1 = 8'($urandom & $urandom & $urandom);
      run_bist(1'b0, m0, m1, 1'b0, 8'h00, $urandom_range(1, 128));
    end
    run_bist(1'b0, 8'h00, 8'h00, 1'b1, 8'($urandom), -1);

    run_bist(1'b1, 8'h00, 8'h00, 1'b1, 8'h00, 600);
    check("sat_err", err_b, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
